// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: requester, adder and response signals
// of the shared-adder arbiter, grouped for port connection.
interface adder_share_arbiter_if #(
    parameter int A     = 8,
    parameter int B     = 8,
    parameter int SUM_W = A + 1
);
    logic             i_req0_valid;
    logic             o_req0_ready;
    logic [A-1:0]     i_req0_a;
    logic [B-1:0]     i_req0_b;
    logic             i_req1_valid;
    logic             o_req1_ready;
    logic [A-1:0]     i_req1_a;
    logic [B-1:0]     i_req1_b;
    logic             o_op_valid;
    logic [A-1:0]     o_op_a;
    logic [B-1:0]     o_op_b;
    logic [SUM_W-1:0] i_add_sum;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic             o_rsp_id;
    logic [SUM_W-1:0] o_rsp_sum;

    modport slave (
        input  i_req0_valid, i_req0_a, i_req0_b,
        input  i_req1_valid, i_req1_a, i_req1_b,
        input  i_add_sum, i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_op_valid, o_op_a, o_op_b,
        output o_rsp_valid, o_rsp_id, o_rsp_sum
    );

    modport master (
        output i_req0_valid, i_req0_a, i_req0_b,
        output i_req1_valid, i_req1_a, i_req1_b,
        output i_add_sum, i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_op_valid, o_op_a, o_op_b,
        input  o_rsp_valid, o_rsp_id, o_rsp_sum
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin share of one external adder
// between two requesters, one transaction in flight at a time.
module adder_share_arbiter #(
    parameter int A       = 8,
    parameter int B       = 8,
    parameter int SUM_W   = A + 1,
    parameter int ADD_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    adder_share_arbiter_if.slave bus,
    output logic                 o_busy,
    output logic [15:0]          o_txn_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0] LAT_INIT = 3'(ADD_LAT - 1);

    logic [1:0]       state;
    logic [2:0]       lat_cnt;
    logic             rr_last;
    logic [A-1:0]     op_a;
    logic [B-1:0]     op_b;
    logic             rsp_id;
    logic [SUM_W-1:0] rsp_sum;
    logic [15:0]      txn_cnt;
    logic             gnt0;
    logic             gnt1;

    // Grant in IDLE: a lone requester wins, a tie goes to the
    // channel that was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_reset && state == IDLE) begin
            if (bus.i_req0_valid &&
                (!bus.i_req1_valid || rr_last)) begin
                gnt0 = 1'b1;
            end else if (bus.i_req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Transaction FSM: latch operands, launch, wait, hold response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            rr_last <= 1'b1;
            op_a    <= '0;
            op_b    <= '0;
            rsp_id  <= 1'b0;
            rsp_sum <= '0;
            txn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0) begin
                        op_a    <= bus.i_req0_a;
                        op_b    <= bus.i_req0_b;
                        rsp_id  <= 1'b0;
                        rr_last <= 1'b0;
                        state   <= ISSUE;
                    end else if (gnt1) begin
                        op_a    <= bus.i_req1_a;
                        op_b    <= bus.i_req1_b;
                        rsp_id  <= 1'b1;
                        rr_last <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        rsp_sum <= bus.i_add_sum;
                        state   <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        txn_cnt <= txn_cnt + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req0_ready = gnt0;
    assign bus.o_req1_ready = gnt1;
    assign bus.o_op_valid   = (state == ISSUE);
    assign bus.o_op_a       = op_a;
    assign bus.o_op_b       = op_b;
    assign bus.o_rsp_valid  = (state == RESP);
    assign bus.o_rsp_id     = rsp_id;
    assign bus.o_rsp_sum    = rsp_sum;
    assign o_busy           = (state != IDLE);
    assign o_txn_cnt        = txn_cnt;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: random and directed stimulus with a
// scoreboard of expected responses and an adder stub per DUT.
module tb_adder_share_arbiter;

    localparam int A  = 8;
    localparam int B  = 8;
    localparam int SW = 9;

    typedef struct packed {
        logic          id;
        logic [SW-1:0] sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adder_share_arbiter_if #(.A(A), .B(B), .SUM_W(SW)) bus0 ();
    adder_share_arbiter_if #(.A(A), .B(B), .SUM_W(SW)) bus4 ();

    logic        busy0;
    logic        busy4;
    logic [15:0] cnt0;
    logic [15:0] cnt4;

    adder_share_arbiter #(
        .A(A), .B(B), .SUM_W(SW), .ADD_LAT(1)
    ) u0 (
        .i_clk(clk), .i_reset(rst), .bus(bus0),
        .o_busy(busy0), .o_txn_cnt(cnt0)
    );

    adder_share_arbiter #(
        .A(A), .B(B), .SUM_W(SW), .ADD_LAT(4)
    ) u4 (
        .i_clk(clk), .i_reset(rst), .bus(bus4),
        .o_busy(busy4), .o_txn_cnt(cnt4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb[$];
    int   gnt_log[$];
    int   last_gnt  = 1;
    int   cnt_model = 0;

    function automatic logic [SW-1:0] ref_sum(
        input logic [A-1:0] a, input logic [B-1:0] b);
        int sa;
        int sb_;
        sa  = $signed(a);
        sb_ = $signed(b);
        return SW'(sa + sb_);
    endfunction

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, got, exp);
        end
    endtask

    // Adder stubs: sign-extend, add, present after ADD_LAT cycles.
    logic          p0_v;
    logic [SW-1:0] p0_s;
    logic          p4_v [4];
    logic [SW-1:0] p4_s [4];

    always @(posedge clk) begin
        p0_v <= bus0.o_op_valid;
        p0_s <= ref_sum(bus0.o_op_a, bus0.o_op_b);
        p4_v[0] <= bus4.o_op_valid;
        p4_s[0] <= ref_sum(bus4.o_op_a, bus4.o_op_b);
        for (int i = 1; i < 4; i++) begin
            p4_v[i] <= p4_v[i-1];
            p4_s[i] <= p4_s[i-1];
        end
    end

    assign bus0.i_add_sum = p0_v ? p0_s : 'x;
    assign bus4.i_add_sum = p4_v[3] ? p4_s[3] : 'x;

    // Monitor: model acceptance rules, push expectations, pop on
    // every response handshake.
    logic r0, r1, v0, v1;
    int   ch;
    exp_t e;
    always @(negedge clk) begin
        r0 = bus0.o_req0_ready;
        r1 = bus0.o_req1_ready;
        v0 = bus0.i_req0_valid;
        v1 = bus0.i_req1_valid;
        if (rst) begin
            if (r0 || r1) check("ready_in_reset", 1, 0);
            sb.delete();
            last_gnt  = 1;
            cnt_model = 0;
        end else begin
            if (bus0.o_rsp_valid) begin
                check("rsp_known",
                      32'($isunknown(bus0.o_rsp_sum)), 0);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else if (bus0.i_rsp_ready) begin
                    e = sb.pop_front();
                    check("rsp_id", bus0.o_rsp_id, e.id);
                    check("rsp_sum", bus0.o_rsp_sum, e.sum);
                    cnt_model = (cnt_model + 1) & 16'hFFFF;
                end
            end
            if (r0 || r1) begin
                check("one_ready", 32'(r0 && r1), 0);
                check("ready_needs_valid",
                      32'((r0 && !v0) || (r1 && !v1)), 0);
            end
            if ((r0 && v0) || (r1 && v1)) begin
                ch = (r0 && v0) ? 0 : 1;
                if (v0 && v1)
                    check("rr_order", ch, 1 - last_gnt);
                if (ch == 0)
                    e = '{1'b0, ref_sum(bus0.i_req0_a,
                                        bus0.i_req0_b)};
                else
                    e = '{1'b1, ref_sum(bus0.i_req1_a,
                                        bus0.i_req1_b)};
                sb.push_back(e);
                gnt_log.push_back(ch);
                last_gnt = ch;
            end
        end
    end

    task automatic send(input int ch, input logic [7:0] a,
                        input logic [7:0] b, output int t);
        @(posedge clk);
        #1;
        if (ch == 0) begin
            bus0.i_req0_a = a;
            bus0.i_req0_b = b;
            bus0.i_req0_valid = 1'b1;
        end else begin
            bus0.i_req1_a = a;
            bus0.i_req1_b = b;
            bus0.i_req1_valid = 1'b1;
        end
        t = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ch == 0 ? bus0.o_req0_ready
                        : bus0.o_req1_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus0.i_req0_valid = 1'b0;
        bus0.i_req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        bus0.i_req0_valid = 1'b0;
        bus0.i_req1_valid = 1'b0;
        k = 0;
        while ((sb.size() != 0 || busy0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(k < 200), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_txn(input int ch, input logic [7:0] a,
                           input logic [7:0] b,
                           input logic [SW-1:0] exp_sum,
                           output int op_lat,
                           output int rsp_lat);
        int t;
        send(ch, a, b, t);
        op_lat  = -1;
        rsp_lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus0.o_op_valid && op_lat < 0)
                op_lat = cyc - t;
            if (bus0.o_rsp_valid) begin
                rsp_lat = cyc - t;
                check("txn_id", bus0.o_rsp_id, ch);
                check("txn_sum", bus0.o_rsp_sum, exp_sum);
                break;
            end
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    int          t;
    int          ol;
    int          rl;
    int          n;
    logic [7:0]  a4;
    logic [7:0]  b4;
    logic [SW-1:0] s4;

    initial begin
        bus0.i_req0_valid = 1'b1;
        bus0.i_req0_a = 8'h11;
        bus0.i_req0_b = 8'h22;
        bus0.i_req1_valid = 1'b0;
        bus0.i_req1_a = '0;
        bus0.i_req1_b = '0;
        bus0.i_rsp_ready = 1'b1;
        bus4.i_req0_valid = 1'b0;
        bus4.i_req0_a = '0;
        bus4.i_req0_b = '0;
        bus4.i_req1_valid = 1'b0;
        bus4.i_req1_a = '0;
        bus4.i_req1_b = '0;
        bus4.i_rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_op_valid", bus0.o_op_valid, 0);
        check("rst_op_a", bus0.o_op_a, 0);
        check("rst_op_b", bus0.o_op_b, 0);
        check("rst_rsp_valid", bus0.o_rsp_valid, 0);
        check("rst_rsp_id", bus0.o_rsp_id, 0);
        check("rst_rsp_sum", bus0.o_rsp_sum, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_ready0", bus0.o_req0_ready, 0);
        @(posedge clk);
        #1;
        bus0.i_req0_valid = 1'b0;
        rst = 1'b0;

        run_txn(0, 8'h30, 8'h14, 9'h044, ol, rl);
        check("t1_op_lat", ol, 1);
        check("t1_rsp_lat", rl, 3);
        check("t1_cnt", cnt0, 1);

        run_txn(1, 8'hFC, 8'h04, 9'h000, ol, rl);
        run_txn(1, 8'h80, 8'h80, 9'h100, ol, rl);
        check("t2_cnt", cnt0, 3);

        gnt_log.delete();
        @(posedge clk);
        #1;
        bus0.i_req0_a = 8'($urandom);
        bus0.i_req0_b = 8'($urandom);
        bus0.i_req1_a = 8'($urandom);
        bus0.i_req1_b = 8'($urandom);
        bus0.i_req0_valid = 1'b1;
        bus0.i_req1_valid = 1'b1;
        n = 0;
        while (gnt_log.size() < 4 && n < 100) begin
            @(negedge clk);
            r0 = bus0.o_req0_ready;
            r1 = bus0.o_req1_ready;
            @(posedge clk);
            #1;
            if (r0) begin
                bus0.i_req0_a = 8'($urandom);
                bus0.i_req0_b = 8'($urandom);
            end
            if (r1) begin
                bus0.i_req1_a = 8'($urandom);
                bus0.i_req1_b = 8'($urandom);
            end
            n++;
        end
        wait_idle();
        if (gnt_log.size() < 4) begin
            check("t3_grants", gnt_log.size(), 4);
        end else begin
            for (int i = 0; i < 4; i++)
                check("t3_order", gnt_log[i], i % 2);
        end

        bus0.i_rsp_ready = 1'b0;
        send(0, 8'($urandom), 8'($urandom), t);
        bus0.i_req1_a = 8'h05;
        bus0.i_req1_b = 8'hF0;
        bus0.i_req1_valid = 1'b1;
        n = 0;
        while (!bus0.o_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_rsp_seen", bus0.o_rsp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", bus0.o_rsp_valid, 1);
            if (sb.size() > 0) begin
                check("t4_hold_id", bus0.o_rsp_id, sb[0].id);
                check("t4_hold_sum", bus0.o_rsp_sum, sb[0].sum);
            end
            check("t4_no_ready",
                  32'(bus0.o_req0_ready | bus0.o_req1_ready), 0);
            check("t4_no_launch", bus0.o_op_valid, 0);
        end
        @(posedge clk);
        #1;
        bus0.i_rsp_ready = 1'b1;
        gnt_log.delete();
        n = 0;
        while (gnt_log.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        wait_idle();
        check("t4_ch1_next", gnt_log.size() > 0 ? gnt_log[0] : 9, 1);

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            a4 = 8'($urandom);
            b4 = 8'($urandom);
            bus4.i_req1_a = a4;
            bus4.i_req1_b = b4;
            bus4.i_req1_valid = 1'b1;
            t = -1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus4.o_req1_ready) begin
                    t = cyc;
                    break;
                end
            end
            check("t5_accept", 32'(t >= 0), 1);
            s4 = ref_sum(a4, b4);
            @(posedge clk);
            #1;
            bus4.i_req1_valid = 1'b0;
            ol = -1;
            rl = -1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                check("t5_known",
                      32'($isunknown(bus4.o_rsp_sum)), 0);
                if (bus4.o_op_valid && ol < 0) ol = cyc - t;
                if (bus4.o_rsp_valid) begin
                    rl = cyc - t;
                    check("t5_sum", bus4.o_rsp_sum, s4);
                    check("t5_id", bus4.o_rsp_id, 1);
                    break;
                end
            end
            check("t5_op_lat", ol, 1);
            check("t5_rsp_lat", rl, 6);
        end
        repeat (3) @(negedge clk);
        check("t5_cnt", cnt4, 2);

        send(0, 8'h12, 8'h34, t);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy", busy0, 0);
        check("t6_op_valid", bus0.o_op_valid, 0);
        check("t6_op_a", bus0.o_op_a, 0);
        check("t6_op_b", bus0.o_op_b, 0);
        check("t6_rsp_valid", bus0.o_rsp_valid, 0);
        check("t6_rsp_sum", bus0.o_rsp_sum, 0);
        check("t6_cnt", cnt0, 0);
        repeat (5) begin
            @(negedge clk);
            check("t6_no_rsp", bus0.o_rsp_valid, 0);
        end
        gnt_log.delete();
        @(posedge clk);
        #1;
        bus0.i_req0_valid = 1'b1;
        bus0.i_req1_valid = 1'b1;
        n = 0;
        while (gnt_log.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        wait_idle();
        check("t6_ch0_first",
              gnt_log.size() > 0 ? gnt_log[0] : 9, 0);

        force u0.txn_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release u0.txn_cnt;
        cnt_model = 16'hFFFF;
        @(negedge clk);
        check("t6_preload", cnt0, 16'hFFFF);
        run_txn(1, 8'h7F, 8'h01, 9'h080, ol, rl);
        check("t6_wrap", cnt0, 0);

        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            bus0.i_req0_valid = 1'($urandom_range(0, 1));
            bus0.i_req1_valid = 1'($urandom_range(0, 1));
            bus0.i_req0_a = 8'($urandom);
            bus0.i_req0_b = 8'($urandom);
            bus0.i_req1_a = 8'($urandom);
            bus0.i_req1_b = 8'($urandom);
            bus0.i_rsp_ready = ($urandom_range(0, 9) < 7);
        end
        bus0.i_rsp_ready = 1'b1;
        wait_idle();
        check("rand_cnt", cnt0, cnt_model);
        check("rand_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
